// File: rtl/alu_pipe_if.sv
// Operand/result bundle between operand fetch, alu_pipe and writeback.
// A beat moves on a rising edge where valid && ready; the producer holds payload stable while valid && !ready.
interface alu_pipe_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] S1;
    logic [WIDTH-1:0] S2;
    logic [3:0]       OpCode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] OUT;
    logic             out_zero;
    logic             out_carry;
    logic             out_ovf;
    logic             out_illegal;

    modport slave (
        input  in_valid, S1, S2, OpCode, out_ready,
        output in_ready, out_valid, OUT, out_zero, out_carry, out_ovf, out_illegal
    );

    modport master (
        output in_valid, S1, S2, OpCode, out_ready,
        input  in_ready, out_valid, OUT, out_zero, out_carry, out_ovf, out_illegal
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with status flags, an iterative shift-add multiplier and output backpressure.
// Single-cycle ops land in the output register on the accept edge; MUL goes through MULT/HOLD.
module alu_pipe #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    alu_pipe_if.slave   bus,
    output logic [1:0]  state_dbg
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, HOLD = 2'd2} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [SHW-1:0]   cnt;

    logic             accept, is_mul, out_free;
    logic [WIDTH:0]   sum, diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res;
    logic             res_carry, res_ovf, res_ill;

    assign state_dbg    = state;
    assign out_free     = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = !rst && (state == IDLE) && out_free;
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_mul       = MUL_EN && (bus.OpCode == 4'b1001);
    assign shamt        = bus.S2[SHW-1:0];

    always_comb begin
        res       = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        res_ill   = 1'b0;
        sum       = {1'b0, bus.S1} + {1'b0, bus.S2};
        diff      = {1'b0, bus.S1} - {1'b0, bus.S2};
        case (bus.OpCode)
            4'b0000: begin
                res       = sum[WIDTH-1:0];
                res_carry = sum[WIDTH];
                res_ovf   = (bus.S1[WIDTH-1] == bus.S2[WIDTH-1]) && (sum[WIDTH-1] != bus.S1[WIDTH-1]);
            end
            4'b0001: res = bus.S1 << shamt;
            4'b0010: res = {{(WIDTH-1){1'b0}}, ($signed(bus.S1) < $signed(bus.S2))};
            4'b0011: res = {{(WIDTH-1){1'b0}}, (bus.S1 > bus.S2)};
            4'b0100: res = bus.S1 ^ bus.S2;
            4'b0101: res = bus.S1 >> shamt;
            4'b0110: res = bus.S1 | bus.S2;
            4'b0111: res = bus.S1 & bus.S2;
            4'b1000: begin
                res       = diff[WIDTH-1:0];
                res_carry = diff[WIDTH];
                res_ovf   = (bus.S1[WIDTH-1] != bus.S2[WIDTH-1]) && (diff[WIDTH-1] != bus.S1[WIDTH-1]);
            end
            // MUL result is produced by the FSM; here it only matters when the multiplier is absent
            4'b1001: res_ill = !MUL_EN;
            4'b1101: res = WIDTH'($signed(bus.S1) >>> shamt);
            default: res_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && is_mul) state_nx = MULT;
            MULT:    if (cnt == '0) state_nx = HOLD;
            HOLD:    if (out_free) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (accept && is_mul) begin
            acc    <= '0;
            mcand  <= bus.S1;
            mplier <= bus.S2;
            cnt    <= SHW'(WIDTH - 1);
        end else if (state == MULT) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
        end
    end

    // Refill takes priority over drain so an accept on a draining edge keeps out_valid high
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid   <= 1'b0;
            bus.OUT         <= '0;
            bus.out_zero    <= 1'b0;
            bus.out_carry   <= 1'b0;
            bus.out_ovf     <= 1'b0;
            bus.out_illegal <= 1'b0;
        end else if (accept && !is_mul) begin
            bus.out_valid   <= 1'b1;
            bus.OUT         <= res;
            bus.out_zero    <= (res == '0);
            bus.out_carry   <= res_carry;
            bus.out_ovf     <= res_ovf;
            bus.out_illegal <= res_ill;
        end else if (state == HOLD && out_free) begin
            bus.out_valid   <= 1'b1;
            bus.OUT         <= acc;
            bus.out_zero    <= (acc == '0);
            bus.out_carry   <= 1'b0;
            bus.out_ovf     <= 1'b0;
            bus.out_illegal <= 1'b0;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: driver pushes expected {OUT,zero,carry,ovf,illegal} words,
// a monitor pops and compares on every output transfer.
module tb_alu_pipe;
    localparam int W = 36;

    logic clk;
    logic rst;
    logic [1:0] state_dbg, state_dbg2;

    alu_pipe_if #(.WIDTH(32)) bus  ();
    alu_pipe_if #(.WIDTH(32)) bus2 ();

    alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus.slave),  .state_dbg(state_dbg));
    alu_pipe #(.WIDTH(32), .MUL_EN(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave), .state_dbg(state_dbg2));

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pk(input logic [31:0] o, input logic z, c, v, il);
        return {o, z, c, v, il};
    endfunction

    function automatic logic [W-1:0] act(input int which);
        if (which == 0) return {bus.OUT, bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_illegal};
        return {bus2.OUT, bus2.out_zero, bus2.out_carry, bus2.out_ovf, bus2.out_illegal};
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // driver
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [W-1:0] e);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.OpCode   = op;
        bus.S1       = a;
        bus.S2       = b;
        exp_q.push_back(e);
        #1;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (n >= 200) begin
            n_fail++;
            $display("FAIL accept_timeout: op %b never accepted", op);
            void'(exp_q.pop_back());
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        #2;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h with empty queue", act(0));
            end else begin
                check("result", act(0), exp_q.pop_front());
            end
        end
    end

    initial begin
        int n;
        logic busy_err;
        logic [W-1:0] snap;
        logic have_snap;

        bus.in_valid  = 1'b0; bus.S1 = '0; bus.S2 = '0; bus.OpCode = '0; bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.S1 = '0; bus2.S2 = '0; bus2.OpCode = '0; bus2.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_state", {act(0), bus.out_valid, bus.in_ready, state_dbg}, {36'h0, 1'b0, 1'b0, 2'd0});
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_reset", {35'h0, bus.in_ready}, 36'h1);

        // first ADD and its one-cycle latency
        send(4'b0000, 32'hFFFF_FFFF, 32'h1, pk(32'h0, 1, 1, 0, 0));
        @(negedge clk);
        #1;
        check("add_latency", {35'h0, bus.out_valid}, 36'h1);

        // back-to-back single-cycle ops
        send(4'b1000, 32'h8000_0000, 32'h1,        pk(32'h7FFF_FFFF, 0, 0, 1, 0));
        send(4'b1000, 32'h1,         32'h2,        pk(32'hFFFF_FFFF, 0, 1, 0, 0));
        send(4'b1101, 32'h8000_0000, 32'h24,       pk(32'hF800_0000, 0, 0, 0, 0));
        send(4'b0101, 32'h8000_0000, 32'h24,       pk(32'h0800_0000, 0, 0, 0, 0));
        send(4'b0001, 32'h1,         32'h21,       pk(32'h2,         0, 0, 0, 0));
        send(4'b0010, 32'hFFFF_FFFF, 32'h1,        pk(32'h1,         0, 0, 0, 0));
        send(4'b0011, 32'hFFFF_FFFF, 32'h1,        pk(32'h1,         0, 0, 0, 0));
        send(4'b0010, 32'h1,         32'hFFFF_FFFF, pk(32'h0,        1, 0, 0, 0));
        send(4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, pk(32'h0FF0_0FF0, 0, 0, 0, 0));
        send(4'b0110, 32'hF0F0_F0F0, 32'h0F0F_0000, pk(32'hFFFF_F0F0, 0, 0, 0, 0));
        send(4'b0111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, pk(32'h00F0_00F0, 0, 0, 0, 0));
        send(4'b0000, 32'h7FFF_FFFF, 32'h1,        pk(32'h8000_0000, 0, 0, 1, 0));
        send(4'b1111, 32'h1234_5678, 32'h9,        pk(32'h0,         1, 0, 0, 1));

        // MUL latency and in_ready low while busy
        send(4'b1001, 32'h0001_0001, 32'h0000_FFFF, pk(32'hFFFF_FFFF, 0, 0, 0, 0));
        n = 0;
        busy_err = 1'b0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.out_valid) break;
            if (bus.in_ready) busy_err = 1'b1;
        end
        check("mul_latency", 36'(n), 36'd33);
        check("mul_busy_ready", {35'h0, busy_err}, 36'h0);

        // MUL finishing under backpressure
        send(4'b1001, 32'h0000_FFFF, 32'h0000_FFFF, pk(32'hFFFE_0001, 0, 0, 0, 0));
        @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check("mul_held", {act(0), bus.out_valid, bus.in_ready}, {pk(32'hFFFE_0001, 0, 0, 0, 0), 1'b1, 1'b0});
        @(negedge clk);
        bus.out_ready = 1'b1;

        // four back-to-back ADDs into a stalled output
        @(negedge clk);
        bus.out_ready = 1'b0;
        have_snap = 1'b0;
        fork
            begin
                send(4'b0000, 32'h1,    32'h2,    pk(32'h3,    0, 0, 0, 0));
                send(4'b0000, 32'd10,   32'd20,   pk(32'd30,   0, 0, 0, 0));
                send(4'b0000, 32'd100,  32'd200,  pk(32'd300,  0, 0, 0, 0));
                send(4'b0000, 32'h1000, 32'h2000, pk(32'h3000, 0, 0, 0, 0));
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    #1;
                    if (bus.out_valid) begin
                        if (!have_snap) begin
                            snap = act(0);
                            have_snap = 1'b1;
                        end
                        check("bp_hold", act(0), snap);
                        check("bp_in_ready", {35'h0, bus.in_ready}, 36'h0);
                    end
                end
                @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        check("bp_first_held", snap, pk(32'h3, 0, 0, 0, 0));

        // reset in the middle of a MUL
        send(4'b1001, 32'd3, 32'd5, pk(32'd15, 0, 0, 0, 0));
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_abort", {34'h0, bus.out_valid, bus.in_ready}, 36'h1);
        exp_q.delete();
        send(4'b0000, 32'd5, 32'd6, pk(32'd11, 0, 0, 0, 0));

        // MUL opcode on the multiplier-less build
        @(negedge clk);
        bus2.in_valid = 1'b1;
        bus2.OpCode   = 4'b1001;
        bus2.S1       = 32'd3;
        bus2.S2       = 32'd4;
        #1;
        check("nomul_ready", {35'h0, bus2.in_ready}, 36'h1);
        @(posedge clk);
        #1 bus2.in_valid = 1'b0;
        check("nomul_illegal", {act(1)}, pk(32'h0, 1, 0, 0, 1));
        check("nomul_valid", {34'h0, bus2.out_valid, state_dbg2 == 2'd0}, 36'h3);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("queue_drained", 36'(exp_q.size()), 36'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
